call_panel: RTL and testbench
=============================

CALL_PANEL -- requirements
Module: call_panel

Interface
REQ-001 Parameter DEBOUNCE, default 4, meaning: consecutive synchronized samples (legal range 1..15) a button level must hold before it is accepted.
REQ-002 Parameter TIMEOUT, default 255, meaning: cycles a request may stay pending before its overdue flag sets (legal range 1..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn  input  4  raw, asynchronous, bouncy floor call buttons; bit f = floor f, 1 = pressed.
REQ-006 door_open  input  1  elevator controller door-open indication.
REQ-007 curr_floor  input  2  elevator controller current floor.
REQ-008 req  output  4  latched pending requests, fed to the elevator controller req input.
REQ-009 lamp  output  4  call-acknowledge lamps; always equal to req.
REQ-010 overdue  output  4  bit f = 1 while req[f] has been pending for TIMEOUT or more cycles.

Function
REQ-011 Each btn bit SHALL pass through a two-flop synchronizer before any other use.
REQ-012 Each floor SHALL have an independent debounce FSM with states LOW, RISE_WAIT, HIGH, FALL_WAIT and a 4-bit stability counter.
REQ-013 LOW: synchronized 1 -> RISE_WAIT with counter = 1; otherwise stay.
REQ-014 RISE_WAIT: synchronized 1 -> counter + 1, entering HIGH when the counter reaches DEBOUNCE; synchronized 0 -> LOW with counter = 0.
REQ-015 HIGH and FALL_WAIT SHALL mirror RISE_WAIT and LOW for a falling level, returning to LOW after DEBOUNCE consecutive 0 samples; a 1 sample in FALL_WAIT -> HIGH.
REQ-016 With DEBOUNCE = 1, RISE_WAIT and FALL_WAIT SHALL be skipped: one sample moves LOW <-> HIGH directly.
REQ-017 An accepted press is the clock edge on which a floor FSM enters HIGH from LOW or RISE_WAIT; re-entry to HIGH from FALL_WAIT is not a press.
REQ-018 An accepted press on floor f SHALL set req[f] on that same edge.
REQ-019 Latency: a clean btn rising edge SHALL make req[f] visible 2 + DEBOUNCE clock edges after the first edge that samples it high.
REQ-020 A held button SHALL produce exactly one press; a bounce shorter than DEBOUNCE samples SHALL produce none.
REQ-021 While door_open = 1, req[curr_floor] SHALL be cleared on every rising edge.
REQ-022 A press on floor f == curr_floor while door_open = 1 SHALL be discarded: clear wins.
REQ-023 Presses on other floors SHALL be latched normally while the door is open.
REQ-024 A request SHALL never clear other than through REQ-021 or reset.
REQ-025 Setting req[f] when it is already 1 SHALL have no effect; the pending timer is not restarted.
REQ-026 Each floor SHALL have an 8-bit wait counter: 0 while req[f] = 0, +1 per cycle while req[f] = 1, saturating at TIMEOUT.
REQ-027 overdue[f] SHALL be registered high when the wait counter equals TIMEOUT.
REQ-028 Clearing req[f] SHALL zero the floor-f wait counter and overdue[f] on the same edge.
REQ-029 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-030 reset = 0 SHALL immediately force req = 0, lamp = 0, overdue = 0, all FSMs to LOW, and all counters and synchronizer flops to 0, regardless of the clock.
REQ-031 A button held through reset release SHALL be accepted as a new press after 2 + DEBOUNCE edges.
REQ-032 Reset asserted mid-debounce or mid-timeout SHALL discard all progress.

Verification (DEBOUNCE = 4, TIMEOUT = 10)
REQ-033 Clean press: btn[2] 0 -> 1 and held -> req = 4'b0100 after exactly 6 edges; it stays set after release; lamp = req.
REQ-034 Bounce: btn[1] pulses 1 for 3 cycles, then 0 -> req stays 0; then held 1 for 4 stable samples -> req[1] = 1.
REQ-035 Service: req = 4'b1010, curr_floor = 3, door_open = 1 for one cycle -> req = 4'b0010 and overdue[3] = 0 on the next edge.
REQ-036 Clear wins: door_open = 1 with curr_floor = 0 while btn[0] completes its debounce -> req[0] stays 0; a simultaneous floor-2 press -> req[2] = 1.
REQ-037 Timeout: req[1] set, no service -> overdue[1] = 1 on the 10th edge after req[1] rose, and held; door service at floor 1 -> both clear on one edge.
REQ-038 Async reset: assert reset = 0 between clock edges with req = 4'b1111 -> req, lamp, and overdue read 0 before the next edge.

Source files
------------

// File: rtl/call_panel.sv
// Hall call panel: synchronizes and debounces four floor buttons, latches the
// accepted presses as pending requests, and flags requests left unserved too long.
module call_panel #(
   parameter int DEBOUNCE = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn,
   input  logic       door_open,
   input  logic [1:0] curr_floor,
   output logic [3:0] req,
   output logic [3:0] lamp,
   output logic [3:0] overdue
);

   typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} deb_state_t;

   localparam logic [3:0] DEB_LIM  = 4'(DEBOUNCE);
   localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT);

   logic [3:0] sync_a;
   logic [3:0] sync_b;
   deb_state_t state      [4];
   deb_state_t state_next [4];
   logic [3:0] cnt        [4];
   logic [3:0] cnt_next   [4];
   logic [3:0] press;
   logic [3:0] clear;
   logic [3:0] req_next;
   logic [7:0] wait_cnt   [4];
   logic [7:0] wait_next  [4];
   logic [3:0] overdue_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= btn;
         sync_b <= sync_a;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int f = 0; f < 4; f++) begin
            state[f] <= LOW;
            cnt[f]   <= '0;
         end
      end else begin
         for (int f = 0; f < 4; f++) begin
            state[f] <= state_next[f];
            cnt[f]   <= cnt_next[f];
         end
      end
   end

   // A press is only the LOW/RISE_WAIT -> HIGH transition; FALL_WAIT -> HIGH is a glitch recovery.
   always_comb begin
      press = '0;
      for (int f = 0; f < 4; f++) begin
         state_next[f] = state[f];
         cnt_next[f]   = cnt[f];
         case (state[f])
            LOW: begin
               if (sync_b[f]) begin
                  if (DEB_LIM == 4'd1) begin
                     state_next[f] = HIGH;
                     cnt_next[f]   = '0;
                     press[f]      = 1'b1;
                  end else begin
                     state_next[f] = RISE_WAIT;
                     cnt_next[f]   = 4'd1;
                  end
               end
            end
            RISE_WAIT: begin
               if (sync_b[f]) begin
                  if (cnt[f] + 4'd1 == DEB_LIM) begin
                     state_next[f] = HIGH;
                     cnt_next[f]   = '0;
                     press[f]      = 1'b1;
                  end else begin
                     cnt_next[f] = cnt[f] + 4'd1;
                  end
               end else begin
                  state_next[f] = LOW;
                  cnt_next[f]   = '0;
               end
            end
            HIGH: begin
               if (!sync_b[f]) begin
                  if (DEB_LIM == 4'd1) begin
                     state_next[f] = LOW;
                     cnt_next[f]   = '0;
                  end else begin
                     state_next[f] = FALL_WAIT;
                     cnt_next[f]   = 4'd1;
                  end
               end
            end
            FALL_WAIT: begin
               if (!sync_b[f]) begin
                  if (cnt[f] + 4'd1 == DEB_LIM) begin
                     state_next[f] = LOW;
                     cnt_next[f]   = '0;
                  end else begin
                     cnt_next[f] = cnt[f] + 4'd1;
                  end
               end else begin
                  state_next[f] = HIGH;
                  cnt_next[f]   = '0;
               end
            end
            default: begin
               state_next[f] = LOW;
               cnt_next[f]   = '0;
            end
         endcase
      end
   end

   // Door service at the current floor overrides a same-edge press on that floor.
   always_comb begin
      clear        = '0;
      req_next     = '0;
      overdue_next = '0;
      for (int f = 0; f < 4; f++) begin
         clear[f]    = door_open && (curr_floor == 2'(f));
         req_next[f] = (req[f] | press[f]) & ~clear[f];
         if (clear[f] || !req[f]) begin
            wait_next[f] = '0;
         end else if (wait_cnt[f] >= WAIT_LIM) begin
            wait_next[f] = WAIT_LIM;
         end else begin
            wait_next[f] = wait_cnt[f] + 8'd1;
         end
         overdue_next[f] = req_next[f] && (wait_next[f] == WAIT_LIM);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req     <= '0;
         overdue <= '0;
         for (int f = 0; f < 4; f++) begin
            wait_cnt[f] <= '0;
         end
      end else begin
         req     <= req_next;
         overdue <= overdue_next;
         for (int f = 0; f < 4; f++) begin
            wait_cnt[f] <= wait_next[f];
         end
      end
   end

   assign lamp = req;

endmodule

// File: tb/tb_call_panel.sv
// Bench for call_panel: directed scenarios plus random bouncy buttons, all
// compared every cycle against a behavioural model of the call panel.
module tb_call_panel;

   localparam int DEB = 4;
   localparam int TMO = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn;
   logic       door_open;
   logic [1:0] curr_floor;
   logic [3:0] req;
   logic [3:0] lamp;
   logic [3:0] overdue;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   call_panel #(.DEBOUNCE(DEB), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .btn        (btn),
      .door_open  (door_open),
      .curr_floor (curr_floor),
      .req        (req),
      .lamp       (lamp),
      .overdue    (overdue)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: button levels seen two edges late; a level is accepted once the
   // last DEB samples all disagree with the currently accepted level.
   logic [3:0]  btn_q[$];
   logic [15:0] hist [4];
   logic [3:0]  acc;
   logic [3:0]  m_req;
   int          pend [4];

   task automatic model_step();
      logic [3:0]  s;
      logic [3:0]  pr;
      logic [15:0] mask;
      if (!reset) begin
         btn_q.delete();
         acc   = '0;
         m_req = '0;
         for (int f = 0; f < 4; f++) begin
            hist[f] = '0;
            pend[f] = 0;
         end
         return;
      end
      btn_q.push_back(btn);
      s = (btn_q.size() >= 3) ? btn_q[btn_q.size() - 3] : 4'b0000;
      while (btn_q.size() > 3) void'(btn_q.pop_front());
      mask = 16'((1 << DEB) - 1);
      pr   = '0;
      for (int f = 0; f < 4; f++) begin
         hist[f] = {hist[f][14:0], s[f]};
         if (!acc[f] && ((hist[f] & mask) == mask)) begin
            acc[f] = 1'b1;
            pr[f]  = 1'b1;
         end else if (acc[f] && ((hist[f] & mask) == 16'd0)) begin
            acc[f] = 1'b0;
         end
      end
      for (int f = 0; f < 4; f++) begin
         if (door_open && (curr_floor == f)) begin
            m_req[f] = 1'b0;
            pend[f]  = 0;
         end else if (m_req[f]) begin
            if (pend[f] < 255) pend[f] = pend[f] + 1;
         end else if (pr[f]) begin
            m_req[f] = 1'b1;
            pend[f]  = 0;
         end
      end
   endtask

   function automatic logic [3:0] model_ovd();
      logic [3:0] o;
      for (int f = 0; f < 4; f++) o[f] = m_req[f] && (pend[f] >= TMO);
      return o;
   endfunction

   always begin
      @(posedge clk);
      model_step();
      #1;
      check_val("model_req", {28'd0, req}, {28'd0, m_req});
      check_val("model_lamp", {28'd0, lamp}, {28'd0, m_req});
      check_val("model_overdue", {28'd0, overdue}, {28'd0, model_ovd()});
   end

   initial begin
      reset      = 1'b0;
      btn        = '0;
      door_open  = 1'b0;
      curr_floor = '0;
      repeat (3) @(negedge clk);
      check_val("reset_req", {28'd0, req}, 32'h0);
      check_val("reset_lamp", {28'd0, lamp}, 32'h0);
      check_val("reset_overdue", {28'd0, overdue}, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // clean press latency
      btn = 4'b0100;
      repeat (5) @(negedge clk);
      check_val("press_early", {28'd0, req}, 32'h0);
      @(negedge clk);
      check_val("press_latency", {28'd0, req}, 32'h4);
      btn = '0;
      repeat (20) @(negedge clk);
      check_val("press_held_req", {28'd0, req}, 32'h4);
      check_val("press_held_lamp", {28'd0, lamp}, 32'h4);
      check_val("press_overdue", {28'd0, overdue}, 32'h4);

      // bounce then stable press
      btn[1] = 1'b1;
      repeat (3) @(negedge clk);
      btn[1] = 1'b0;
      repeat (10) @(negedge clk);
      check_val("bounce_none", {28'd0, req}, 32'h4);
      btn[1] = 1'b1;
      repeat (6) @(negedge clk);
      check_val("bounce_stable", {28'd0, req}, 32'h6);
      btn[3] = 1'b1;
      repeat (6) @(negedge clk);
      check_val("press_floor3", {28'd0, req}, 32'hE);

      // service floors 2 then 3
      door_open  = 1'b1;
      curr_floor = 2'd2;
      @(negedge clk);
      door_open = 1'b0;
      check_val("service_f2", {28'd0, req}, 32'hA);
      door_open  = 1'b1;
      curr_floor = 2'd3;
      @(negedge clk);
      door_open = 1'b0;
      check_val("service_f3", {28'd0, req}, 32'h2);
      check_val("service_ovd3", {31'd0, overdue[3]}, 32'h0);

      // timeout on floor 1
      btn = '0;
      repeat (8) @(negedge clk);
      door_open  = 1'b1;
      curr_floor = 2'd1;
      @(negedge clk);
      door_open = 1'b0;
      check_val("clear_f1", {28'd0, req}, 32'h0);
      btn[1] = 1'b1;
      repeat (6) @(negedge clk);
      check_val("timeout_req", {31'd0, req[1]}, 32'h1);
      repeat (9) @(negedge clk);
      check_val("timeout_before", {31'd0, overdue[1]}, 32'h0);
      @(negedge clk);
      check_val("timeout_set", {31'd0, overdue[1]}, 32'h1);
      repeat (3) @(negedge clk);
      check_val("timeout_hold", {31'd0, overdue[1]}, 32'h1);
      door_open  = 1'b1;
      curr_floor = 2'd1;
      @(negedge clk);
      door_open = 1'b0;
      check_val("timeout_clr_req", {28'd0, req}, 32'h0);
      check_val("timeout_clr_ovd", {28'd0, overdue}, 32'h0);

      // clear wins at the open floor, other floors still latch
      btn = '0;
      repeat (8) @(negedge clk);
      door_open  = 1'b1;
      curr_floor = 2'd0;
      btn        = 4'b0101;
      repeat (8) @(negedge clk);
      check_val("clear_wins", {28'd0, req}, 32'h4);
      door_open = 1'b0;
      repeat (3) @(negedge clk);
      check_val("clear_wins_after", {28'd0, req}, 32'h4);

      // async reset with all requests pending
      btn = '0;
      repeat (8) @(negedge clk);
      btn = 4'b1111;
      repeat (8) @(negedge clk);
      check_val("all_req", {28'd0, req}, 32'hF);
      #2 reset = 1'b0;
      #1;
      check_val("async_req", {28'd0, req}, 32'h0);
      check_val("async_lamp", {28'd0, lamp}, 32'h0);
      check_val("async_ovd", {28'd0, overdue}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check_val("held_thru_rst_early", {28'd0, req}, 32'h0);
      @(negedge clk);
      check_val("held_thru_rst", {28'd0, req}, 32'hF);

      // random bouncy buttons, door service and occasional reset
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         for (int f = 0; f < 4; f++) begin
            if ($urandom_range(0, 7) == 0) btn[f] = ~btn[f];
         end
         door_open  = ($urandom_range(0, 9) == 0);
         curr_floor = 2'($urandom_range(0, 3));
         reset      = ($urandom_range(0, 999) != 0);
      end
      reset     = 1'b1;
      door_open = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
